// File: rtl/man_link_ctrl.sv
// rtl/man_link_ctrl.sv - sequencer for the 16-bit SPI-to-Manchester loopback link
//
// Queues SPI words, launches them one at a time into the Manchester encoder,
// waits for the decoded echo (or a deadline), then holds off for a gap.
//
// Ports:
//   clk_in      system clock
//   rst         asynchronous active-high reset
//   rx_flag     pulse: rx_data carries a new SPI word
//   rx_data     SPI received word
//   enc_busy    encoder is transmitting
//   enc_start   pulse: launch enc_data into the encoder
//   enc_data    word being encoded, held until the next launch
//   dec_valid   pulse: dec_data carries a decoded word
//   dec_data    decoded word
//   tx_data     word returned on the next SPI transaction
//   resp_ok     pulse: a response was captured into tx_data
//   timeout     pulse: deadline expired, tx_data loaded with ERR_WORD
//   fifo_full   command queue holds DEPTH words
//   fifo_empty  command queue holds no words
//   drop_cnt    saturating count of words dropped on a full queue
//   busy        sequencer is not idle
`timescale 1ns/1ps
module man_link_ctrl #(
    parameter int          DEPTH        = 4,
    parameter int          GAP_CYC      = 36,
    parameter int          RESP_TIMEOUT = 2400,
    parameter logic [15:0] ERR_WORD     = 16'hDEAD
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        rx_flag,
    input  logic [15:0] rx_data,
    input  logic        enc_busy,
    output logic        enc_start,
    output logic [15:0] enc_data,
    input  logic        dec_valid,
    input  logic [15:0] dec_data,
    output logic [15:0] tx_data,
    output logic        resp_ok,
    output logic        timeout,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (RESP_TIMEOUT > GAP_CYC) ? RESP_TIMEOUT : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, ACTIVE, GAP} state_t;

    state_t        state, state_nx;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nx;
    logic [CW-1:0] cnt;
    logic          got;
    logic [15:0]   resp;
    logic          push, pop;
    logic          cap;
    logic [15:0]   resp_word;

    // Full-ness is the registered flag, so a write while full is dropped
    // even if a launch frees a slot in the same cycle.
    assign push = rx_flag && !fifo_full;
    assign pop  = (state == LAUNCH);
    assign busy = (state != IDLE);

    // Only the first decoded word of a frame is kept.
    assign cap       = (state == ACTIVE) && dec_valid && !got;
    // A word arriving in the exit cycle is forwarded directly.
    assign resp_word = got ? resp : dec_data;

    always_comb begin
        count_nx = count;
        if (push && !pop)
            count_nx = count + 1'b1;
        else if (pop && !push)
            count_nx = count - 1'b1;
    end

    always_comb begin
        state_nx  = state;
        enc_start = 1'b0;
        resp_ok   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !enc_busy)
                    state_nx = LAUNCH;
            end
            LAUNCH: begin
                enc_start = 1'b1;
                state_nx  = ACTIVE;
            end
            ACTIVE: begin
                if ((got || dec_valid) && !enc_busy) begin
                    resp_ok  = 1'b1;
                    state_nx = GAP;
                end else if (cnt == CW'(RESP_TIMEOUT - 1)) begin
                    timeout  = 1'b1;
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYC - 1))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Queue storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_in) begin
        if (push)
            mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            drop_cnt   <= '0;
            enc_data   <= '0;
            tx_data    <= '0;
            cnt        <= '0;
            got        <= 1'b0;
            resp       <= '0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            fifo_full  <= (count_nx == (AW+1)'(DEPTH));
            fifo_empty <= (count_nx == '0);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (rx_flag && fifo_full && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;

            // Head word is presented on the edge entering LAUNCH so that it
            // is already valid while enc_start is high.
            if (state == IDLE && state_nx == LAUNCH)
                enc_data <= mem[rd_ptr];

            if (cap)
                resp <= dec_data;

            case (state)
                LAUNCH: begin
                    cnt <= '0;
                    got <= 1'b0;
                end
                ACTIVE: begin
                    if (dec_valid)
                        got <= 1'b1;
                    if (resp_ok || timeout)
                        cnt <= '0;
                    else
                        cnt <= cnt + 1'b1;
                end
                GAP:     cnt <= cnt + 1'b1;
                default: cnt <= '0;
            endcase

            if (resp_ok)
                tx_data <= resp_word;
            else if (timeout)
                tx_data <= ERR_WORD;
        end
    end

endmodule

// File: tb/tb_man_link_ctrl.sv
// tb/tb_man_link_ctrl.sv - self-checking bench for man_link_ctrl
`timescale 1ns/1ps
module tb_man_link_ctrl;

    localparam int          DEPTH        = 4;
    localparam int          GAP_CYC      = 36;
    localparam int          RESP_TIMEOUT = 2400;
    localparam logic [15:0] ERR_WORD     = 16'hDEAD;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        rx_flag = 1'b0;
    logic [15:0] rx_data = '0;
    logic        enc_busy = 1'b0;
    logic        dec_valid = 1'b0;
    logic [15:0] dec_data = '0;
    logic        enc_start, resp_ok, timeout, fifo_full, fifo_empty, busy;
    logic [15:0] enc_data, tx_data;
    logic [7:0]  drop_cnt;

    man_link_ctrl #(
        .DEPTH(DEPTH), .GAP_CYC(GAP_CYC),
        .RESP_TIMEOUT(RESP_TIMEOUT), .ERR_WORD(ERR_WORD)
    ) dut (
        .clk_in(clk_in), .rst(rst), .rx_flag(rx_flag), .rx_data(rx_data),
        .enc_busy(enc_busy), .enc_start(enc_start), .enc_data(enc_data),
        .dec_valid(dec_valid), .dec_data(dec_data), .tx_data(tx_data),
        .resp_ok(resp_ok), .timeout(timeout), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Event log sampled mid-cycle
    int          lc_q[$];
    logic [15:0] ld_q[$];
    int          rc_q[$];
    int          tc_q[$];
    always @(negedge clk_in) begin
        if (enc_start) begin
            lc_q.push_back(cyc);
            ld_q.push_back(enc_data);
        end
        if (resp_ok) rc_q.push_back(cyc);
        if (timeout) tc_q.push_back(cyc);
    end

    // Reference model: queue of accepted words and the expected drop count
    logic [15:0] exp_q[$];
    int          exp_drop = 0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        rx_flag   = 1'b0;
        dec_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] w);
        step();
        rx_flag = 1'b1;
        rx_data = w;
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else if (exp_drop < 255)  exp_drop++;
    endtask

    task automatic wait_launch(input int budget, input string tag, output int lc);
        lc = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (enc_start) begin
                lc = cyc;
                break;
            end
        end
        if (lc < 0) begin
            n_chk++;
            n_err++;
            $error("FAIL %s no enc_start within %0d cycles", tag, budget);
        end else if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL %s unexpected launch data=%0h", tag, enc_data);
        end else begin
            chk(tag, enc_data, exp_q.pop_front());
        end
    endtask

    task automatic wait_event(input int budget, input string tag);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (rc_q.size() != 0 || tc_q.size() != 0) break;
        end
        if (i == budget) begin
            n_chk++;
            n_err++;
            $error("FAIL %s no resp_ok/timeout within %0d cycles", tag, budget);
        end
    endtask

    initial begin
        int          t0, l, r, t;
        logic [15:0] w, rw;

        // Reset state
        #1 rst = 1'b1;
        repeat (3) step();
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", enc_start, 0);
        chk("rst_flags", {resp_ok, timeout}, 0);
        chk("rst_words", {enc_data, tx_data}, 0);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        repeat (2) step();

        // Single word with a late echo
        send(16'h1234);
        t0 = cyc;
        wait_launch(10, "t1_launch_data", l);
        chk("t1_launch_cyc", l, t0 + 2);
        enc_busy = 1'b1;
        while (cyc < l + 399) step();
        dec_valid = 1'b1;
        dec_data  = 16'h1234;
        step();
        enc_busy = 1'b0;
        step();
        chk("t1_resp_cnt", rc_q.size(), 1);
        r = (rc_q.size() > 0) ? rc_q.pop_front() : -1;
        chk("t1_resp_cyc", r, l + 400);
        chk("t1_tx", tx_data, 16'h1234);
        chk("t1_no_tmo", tc_q.size(), 0);

        // Next launch is held off by the gap; then let it time out
        w = 16'($urandom);
        send(w);
        wait_launch(80, "t2_launch_data", l);
        chk("t2_gap", l, r + GAP_CYC + 2);
        wait_event(RESP_TIMEOUT + 100, "t2_wait");
        chk("t2_tmo_cnt", tc_q.size(), 1);
        t = (tc_q.size() > 0) ? tc_q.pop_front() : -1;
        chk("t2_tmo_cyc", t, l + RESP_TIMEOUT);
        chk("t2_tx_err", tx_data, ERR_WORD);
        chk("t2_no_resp", rc_q.size(), 0);

        // Fill the queue while the encoder is held busy
        enc_busy = 1'b1;
        while (cyc < t + GAP_CYC + 5) step();
        chk("t3_idle", busy, 0);
        for (int i = 0; i < 4; i++) send(16'hA001 + 16'(i));
        step();
        chk("t3_full", fifo_full, 1);
        chk("t3_not_empty", fifo_empty, 0);

        // Overflow: every write is dropped, counter saturates
        for (int i = 0; i < 260; i++) begin
            send(16'($urandom));
            if (i == 9) begin
                step();
                chk("t4_drop_mid", drop_cnt, exp_drop);
            end
        end
        step();
        chk("t4_drop_sat", drop_cnt, exp_drop);
        chk("t4_drop_255", drop_cnt, 255);
        chk("t4_still_full", fifo_full, 1);

        // Drain in order, each echo arriving with the encoder already idle
        enc_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_launch(80, "t3_order", l);
            step();
            step();
            rw        = 16'($urandom);
            dec_valid = 1'b1;
            dec_data  = rw;
            step();
            step();
            r = (rc_q.size() > 0) ? rc_q.pop_front() : -1;
            chk("t3_resp_cyc", r, l + 2);
            chk("t3_tx", tx_data, rw);
        end
        chk("t3_empty", fifo_empty, 1);
        chk("t3_hold_enc", enc_data, 16'hA004);

        // Stray echo in the gap, duplicate echo in the frame
        repeat (3) step();
        dec_valid = 1'b1;
        dec_data  = 16'h5555;
        step();
        step();
        chk("t5_stray_ignored", tx_data, rw);
        send(16'($urandom));
        wait_launch(80, "t5_launch_data", l);
        enc_busy = 1'b1;
        step();
        step();
        dec_valid = 1'b1;
        dec_data  = 16'h0F0F;
        step();
        step();
        dec_valid = 1'b1;
        dec_data  = 16'hFFFF;
        while (cyc < l + 10) step();
        enc_busy = 1'b0;
        step();
        step();
        r = (rc_q.size() > 0) ? rc_q.pop_front() : -1;
        chk("t5_resp_cyc", r, l + 10);
        chk("t5_tx_first", tx_data, 16'h0F0F);

        // Reset in the middle of a frame with two words queued
        while (cyc < l + GAP_CYC + 5) step();
        send(16'($urandom));
        wait_launch(10, "t6_launch_data", l);
        enc_busy = 1'b1;
        send(16'($urandom));
        send(16'($urandom));
        step();
        step();
        chk("t6_pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        exp_drop = 0;
        chk("t6_busy", busy, 0);
        chk("t6_start", enc_start, 0);
        chk("t6_flags", {resp_ok, timeout}, 0);
        chk("t6_empty", fifo_empty, 1);
        chk("t6_full", fifo_full, 0);
        chk("t6_words", {enc_data, tx_data}, 0);
        chk("t6_drop", drop_cnt, exp_drop);
        step();
        step();
        rst      = 1'b0;
        enc_busy = 1'b0;
        lc_q.delete();
        repeat (60) step();
        chk("t6_no_launch", lc_q.size(), 0);
        w = 16'($urandom);
        send(w);
        t0 = cyc;
        wait_launch(10, "t6_relaunch_data", l);
        chk("t6_relaunch_cyc", l, t0 + 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/man_link_ctrl.md
Name: man_link_ctrl

Overview:
- Sequences the 16-bit SPI-to-Manchester loopback link.
- Queues words received by the 16-bit SPI slave and launches them one at a time into the Manchester encoder.
- Waits for the matching word from the Manchester decoder, or times out, then enforces an inter-frame gap before the next launch.
- Drives the word the SPI slave returns on its next transaction: the decoded response, or an error word.

Parameters:
- DEPTH, 4, command FIFO depth in words; power of 2, minimum 2.
- GAP_CYC, 36, idle cycles between frames (3 us at 12 MHz); minimum 1.
- RESP_TIMEOUT, 2400, cycles from launch to response deadline (200 us at 12 MHz).
- ERR_WORD, 16'hDEAD, value loaded into tx_data on timeout.

Ports:
- clk_in  input  1  12 MHz system clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- rx_flag  input  1  one-cycle pulse: rx_data holds a new SPI word.
- rx_data  input  16  SPI received word.
- enc_busy  input  1  encoder is transmitting a frame.
- enc_start  output  1  one-cycle launch pulse to the encoder.
- enc_data  output  16  word to encode; held stable from launch until the next launch.
- dec_valid  input  1  one-cycle pulse: dec_data holds a decoded word.
- dec_data  input  16  decoded word.
- tx_data  output  16  word returned to the SPI slave.
- resp_ok  output  1  one-cycle pulse: a response was captured.
- timeout  output  1  one-cycle pulse: the response deadline expired.
- fifo_full  output  1  FIFO holds DEPTH words.
- fifo_empty  output  1  FIFO holds 0 words.
- drop_cnt  output  8  count of words dropped on a full FIFO; saturates at 255.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, so fifo_empty=1 and fifo_full=0.
  - FSM in IDLE.
  - enc_start, resp_ok, timeout, busy all 0.
  - enc_data, tx_data, drop_cnt all 0.
  - Reset mid-frame abandons the frame and discards all queued words.
- FIFO:
  - Write on rx_flag when !fifo_full.
  - Full-ness is evaluated before a same-cycle pop, so rx_flag while full is dropped even if a pop occurs that cycle. A drop increments drop_cnt; drop_cnt holds at 255.
  - Pointers wrap modulo DEPTH. Flags are registered and reflect occupancy after the current cycle.
- FSM states:
  - IDLE: go to LAUNCH when !fifo_empty && !enc_busy.
  - LAUNCH (1 cycle):
    - Pop the head word into enc_data and assert enc_start=1.
    - Clear the response counter and the got flag. Go to ACTIVE.
    - A word written in the same cycle IDLE sees the FIFO non-empty launches 2 cycles after the rx_flag.
  - ACTIVE:
    - Counter increments each cycle.
    - The first dec_valid latches dec_data into the response register and sets got; later dec_valid pulses are ignored.
    - If got && !enc_busy: tx_data <= response register, resp_ok=1 for 1 cycle, go to GAP.
    - Otherwise, if counter == RESP_TIMEOUT-1: tx_data <= ERR_WORD, timeout=1 for 1 cycle, go to GAP. This applies even if got=1 while enc_busy is stuck high.
    - If both exit conditions hold in the same cycle, resp_ok wins.
    - A dec_valid in the cycle that satisfies the exit condition is captured first, so tx_data gets that cycle's dec_data.
  - GAP: count GAP_CYC cycles, then go to IDLE.
- dec_valid in IDLE, LAUNCH or GAP is ignored.
- tx_data holds its value until the next resp_ok or timeout.
- busy = (state != IDLE).

Test Plan:
- Single word: rx_flag with rx_data=16'h1234, encoder busy for 400 cycles, dec_valid with 16'h1234 at cycle 399 → enc_start exactly 2 cycles after rx_flag, enc_data=16'h1234; resp_ok when busy falls; tx_data=16'h1234; next launch no earlier than 36 cycles later.
- Timeout: launch with no dec_valid → timeout pulse exactly 2400 cycles after enc_start; tx_data=16'hDEAD; resp_ok never asserted.
- Queue order: 4 back-to-back writes 16'hA001..16'hA004 while busy → fifo_full=1 after the 4th; launches in order A001, A002, A003, A004; fifo_empty=1 after the 4th pop.
- Overflow: 260 rx_flag pulses while full → drop_cnt=255 and stays there; FIFO contents unchanged.
- Stray/duplicate responses: dec_valid 16'h5555 during GAP, then in ACTIVE dec_valid 16'h0F0F followed by 16'hFFFF → tx_data=16'h0F0F; the GAP pulse has no effect.
- Reset mid-ACTIVE with 2 words queued: assert rst → all outputs 0 immediately, fifo_empty=1; after release, no enc_start occurs without a new rx_flag.
